// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix/convolution datapath.
// Holds grid dimensions, element widths, the packed-bus index helper and the
// result streamer state encoding. Imported by the convolution unit, the input
// loaders and the result streamer.
package matrix_pkg;

  // Grid geometry and element widths.
  localparam int unsigned MAX_DIM = 5;
  localparam int unsigned ELEM_W  = 16;
  localparam int unsigned IN_W    = 8;
  localparam int unsigned KER_W   = 8;

  // Width of a row/column index or dimension field (holds 0..7).
  localparam int unsigned IDX_W = 3;

  // Total width of a packed MAX_DIM x MAX_DIM result bus.
  localparam int unsigned RES_W = MAX_DIM * MAX_DIM * ELEM_W;

  // Largest legal dimension, expressed in index width for direct compares.
  localparam logic [IDX_W-1:0] MAX_DIM_IDX = IDX_W'(MAX_DIM);

  // Result streamer states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDone   = 2'd2
  } stream_state_e;

  // LSB position of element (r,c) in a packed grid of w-bit elements.
  function automatic int unsigned packed_lsb(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned w);
    return (r * MAX_DIM + c) * w;
  endfunction

endpackage

// File: rtl/conv_elem_sel.sv
// Combinational element selector for a packed result grid.
// Ports:
//   buf_i  - packed MAX_DIM x MAX_DIM grid, element (r,c) at packed_lsb(r,c,ELEM_W)
//   row_i  - row index of the element to read
//   col_i  - column index of the element to read
//   data_o - selected element; zero when (row_i,col_i) lies outside the grid
module conv_elem_sel
  import matrix_pkg::*;
(
  input  logic [RES_W-1:0]  buf_i,
  input  logic [IDX_W-1:0]  row_i,
  input  logic [IDX_W-1:0]  col_i,
  output logic [ELEM_W-1:0] data_o
);

  localparam int unsigned NumElem = MAX_DIM * MAX_DIM;
  localparam int unsigned FlatW   = $clog2(NumElem + 1);

  // Unpack the bus once so the read is a plain array index.
  logic [ELEM_W-1:0] elems [NumElem];

  for (genvar i = 0; i < NumElem; i++) begin : g_unpack
    assign elems[i] = buf_i[packed_lsb(i / MAX_DIM, i % MAX_DIM, ELEM_W) +: ELEM_W];
  end

  logic [FlatW-1:0] flat_idx;
  logic             in_range;

  assign in_range = (row_i < MAX_DIM_IDX) && (col_i < MAX_DIM_IDX);
  // Row-major flat index, only meaningful when in_range.
  assign flat_idx = FlatW'(row_i) * FlatW'(MAX_DIM) + FlatW'(col_i);

  always_comb begin
    data_o = '0;
    if (in_range) begin
      data_o = elems[flat_idx];
    end
  end

endmodule

// File: rtl/conv_result_streamer.sv
// Serialises a captured convolution result into a row-major element stream.
// A start pulse in idle snapshots the packed result and its dimensions; the
// snapshot is then emitted one element per valid/ready handshake with row and
// column tags plus end-of-row and end-of-stream flags. All outputs come from
// registers (or pure decode of registers), never from inputs.
// Ports:
//   clk_i, reset_i       - clock, asynchronous active-high reset
//   start_i              - capture request, honoured only when idle
//   out_m_i, out_n_i     - result rows / columns (1..MAX_DIM)
//   dim_error_i          - producer flagged a bad dimension; start is refused
//   conv_result_i        - packed result grid
//   elem_valid_o/ready_i - element handshake
//   elem_data_o          - element value
//   elem_row_o/col_o     - element coordinates
//   elem_last_col_o      - element ends its row
//   elem_last_o          - element ends the stream
//   busy_o               - streaming or finishing
//   done_o               - one-cycle pulse after the final element is accepted
//   err_o                - one-cycle pulse when a start is refused
module conv_result_streamer
  import matrix_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [IDX_W-1:0]  out_m_i,
  input  logic [IDX_W-1:0]  out_n_i,
  input  logic              dim_error_i,
  input  logic [RES_W-1:0]  conv_result_i,
  output logic              elem_valid_o,
  input  logic              elem_ready_i,
  output logic [ELEM_W-1:0] elem_data_o,
  output logic [IDX_W-1:0]  elem_row_o,
  output logic [IDX_W-1:0]  elem_col_o,
  output logic              elem_last_col_o,
  output logic              elem_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  stream_state_e state_q, state_d;

  logic [RES_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0] m_q, m_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic             err_q, err_d;

  logic start_ok;
  logic streaming;
  logic at_last_col;
  logic at_last;

  // Dimensions are checked against the live inputs at the moment of capture.
  assign start_ok = !dim_error_i
                    && (out_m_i != '0) && (out_n_i != '0)
                    && (out_m_i <= MAX_DIM_IDX) && (out_n_i <= MAX_DIM_IDX);

  assign streaming   = (state_q == StStream);
  assign at_last_col = (col_q == n_q - IDX_W'(1));
  assign at_last     = at_last_col && (row_q == m_q - IDX_W'(1));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    m_d     = m_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (start_ok) begin
            buf_d   = conv_result_i;
            m_d     = out_m_i;
            n_d     = out_n_i;
            row_d   = '0;
            col_d   = '0;
            state_d = StStream;
          end else begin
            // Refused start leaves the previous snapshot untouched.
            err_d = 1'b1;
          end
        end
      end

      StStream: begin
        if (elem_ready_i) begin
          if (at_last) begin
            // Park the indices at the origin so idle shows a stable (0,0).
            row_d   = '0;
            col_d   = '0;
            state_d = StDone;
          end else if (at_last_col) begin
            row_d = row_q + IDX_W'(1);
            col_d = '0;
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      buf_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      m_q     <= m_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
    end
  end

  conv_elem_sel u_elem_sel (
    .buf_i  (buf_q),
    .row_i  (row_q),
    .col_i  (col_q),
    .data_o (elem_data_o)
  );

  // Flags are gated by state so they read zero outside a stream.
  assign elem_valid_o    = streaming;
  assign elem_row_o      = row_q;
  assign elem_col_o      = col_q;
  assign elem_last_col_o = streaming && at_last_col;
  assign elem_last_o     = streaming && at_last;
  assign busy_o          = (state_q != StIdle);
  assign done_o          = (state_q == StDone);
  assign err_o           = err_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Scoreboard bench for conv_result_streamer: the stimulus side pushes the
// expected element stream of each accepted capture, the monitor pops and
// compares on every handshake.
module tb_conv_result_streamer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   out_m;
  logic [2:0]   out_n;
  logic         dim_error;
  logic [399:0] conv_result;
  logic         elem_valid;
  logic         elem_ready;
  logic [15:0]  elem_data;
  logic [2:0]   elem_row;
  logic [2:0]   elem_col;
  logic         elem_last_col;
  logic         elem_last;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  conv_result_streamer dut (
    .clk_i           (clk),
    .reset_i         (rst),
    .start_i         (start),
    .out_m_i         (out_m),
    .out_n_i         (out_n),
    .dim_error_i     (dim_error),
    .conv_result_i   (conv_result),
    .elem_valid_o    (elem_valid),
    .elem_ready_i    (elem_ready),
    .elem_data_o     (elem_data),
    .elem_row_o      (elem_row),
    .elem_col_o      (elem_col),
    .elem_last_col_o (elem_last_col),
    .elem_last_o     (elem_last),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        lc;
    logic        last;
  } elem_t;

  elem_t       sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          xfer_cnt = 0;
  int          ready_mode = 0;
  logic [15:0] vals [25];

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  initial begin
    int phase;
    phase = 0;
    elem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: elem_ready = 1'b1;
        1: begin
          elem_ready = (phase == 0);
          phase = (phase + 1) % 3;
        end
        default: elem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every handshake pops one expected element; a stalled element must
  // be presented unchanged on the following cycle.
  initial begin
    elem_t cur;
    elem_t held;
    elem_t e;
    logic  holding;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 1'b0;
      end else begin
        cur = '{data: elem_data, row: elem_row, col: elem_col,
                lc: elem_last_col, last: elem_last};
        if (holding) begin
          chk("stall_hold", 32'({elem_valid, cur}), 32'({1'b1, held}));
        end
        if (elem_valid && elem_ready) begin
          holding = 1'b0;
          xfer_cnt++;
          if (sb.size() == 0) begin
            chk("unexpected_elem", 32'(cur), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("elem", 32'(cur), 32'(e));
          end
        end else if (elem_valid) begin
          holding = 1'b1;
          held    = cur;
        end else begin
          holding = 1'b0;
        end
      end
    end
  end

  function automatic logic [399:0] pack_vals();
    logic [399:0] v;
    v = '0;
    for (int i = 24; i >= 0; i--) v = {v[383:0], vals[i]};
    return v;
  endfunction

  function automatic logic [399:0] rand_bus();
    logic [399:0] v;
    v = '0;
    for (int i = 0; i < 25; i++) v = {v[383:0], 16'($urandom)};
    return v;
  endfunction

  // 4x4 input 1..16 convolved with a 2x2 all-ones kernel gives a 3x3 result.
  task automatic load_conv3x3();
    int a [4][4];
    for (int i = 0; i < 25; i++) vals[i] = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) a[r][c] = r * 4 + c + 1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        vals[r * 5 + c] = 16'(a[r][c] + a[r][c + 1] + a[r + 1][c] + a[r + 1][c + 1]);
  endtask

  // Issue one start with the current vals; optionally follow it to done.
  // poke: drive a second start with different data in the middle of the stream.
  task automatic issue(input logic [2:0] m, input logic [2:0] n, input logic de,
                       input bit wait_done, input bit poke);
    bit acc;
    int cyc;
    elem_t e;
    acc = !de && m != 0 && n != 0 && m <= 5 && n <= 5;
    conv_result = pack_vals();
    out_m       = m;
    out_n       = n;
    dim_error   = de;
    start       = 1'b1;
    if (acc) begin
      for (int r = 0; r < int'(m); r++)
        for (int c = 0; c < int'(n); c++) begin
          e.data = vals[r * 5 + c];
          e.row  = 3'(r);
          e.col  = 3'(c);
          e.lc   = (c == int'(n) - 1);
          e.last = (c == int'(n) - 1) && (r == int'(m) - 1);
          sb.push_back(e);
        end
    end
    @(posedge clk);
    #1;
    start       = 1'b0;
    conv_result = rand_bus();
    out_m       = 3'($urandom);
    out_n       = 3'($urandom);
    dim_error   = 1'($urandom);
    @(negedge clk);
    chk("err_pulse", 32'(err), 32'(!acc));
    if (!acc) begin
      chk("rej_valid_busy", 32'({elem_valid, busy}), 32'(0));
      @(negedge clk);
      chk("err_single", 32'({err, elem_valid, busy}), 32'(0));
      return;
    end
    if (!wait_done) return;
    cyc = 1;
    while (!done && cyc < 400) begin
      if (poke && cyc == 2) begin
        start       = 1'b1;
        conv_result = rand_bus();
        out_m       = 3'd2;
        out_n       = 3'd2;
        dim_error   = 1'b0;
      end
      if (poke && cyc == 3) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'(1));
    if (ready_mode == 0) chk("stream_cycles", 32'(cyc), 32'(int'(m) * int'(n) + 1));
    chk("sb_drained", 32'(sb.size()), 32'(0));
    @(negedge clk);
    chk("done_single", 32'({done, busy, elem_valid}), 32'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, 32'({elem_valid, elem_data, elem_row, elem_col, elem_last_col,
                   elem_last, busy, done, err}), 32'(0));
  endtask

  initial begin
    int base;
    int k;
    rst         = 1'b1;
    start       = 1'b0;
    out_m       = '0;
    out_n       = '0;
    dim_error   = 1'b0;
    conv_result = '0;
    for (int i = 0; i < 25; i++) vals[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_state");

    // 3x3 convolution result, full throughput.
    load_conv3x3();
    chk("conv_first_value", 32'(vals[0]), 32'(14));
    ready_mode = 0;
    issue(3'd3, 3'd3, 1'b0, 1'b1, 1'b0);

    // Same result with ready pattern 1,0,0.
    ready_mode = 1;
    issue(3'd3, 3'd3, 1'b0, 1'b1, 1'b0);

    // Rejected starts.
    ready_mode = 0;
    issue(3'd3, 3'd3, 1'b1, 1'b1, 1'b0);
    issue(3'd0, 3'd3, 1'b0, 1'b1, 1'b0);
    issue(3'd3, 3'd6, 1'b0, 1'b1, 1'b0);

    // 5x5 grid of (r*5+c)*100.
    for (int i = 0; i < 25; i++) vals[i] = 16'(i * 100);
    issue(3'd5, 3'd5, 1'b0, 1'b1, 1'b0);

    // 1x1 result.
    vals[0] = 16'hBEEF;
    issue(3'd1, 3'd1, 1'b0, 1'b1, 1'b0);

    // Reset after the third transfer of a 3x3 stream, then replay.
    load_conv3x3();
    base = xfer_cnt;
    issue(3'd3, 3'd3, 1'b0, 1'b0, 1'b0);
    k = 0;
    while (xfer_cnt < base + 3 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("reset_wait_xfers", 32'(xfer_cnt - base), 32'(3));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midstream_reset");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset_idle");
    ready_mode = 1;
    issue(3'd3, 3'd3, 1'b0, 1'b1, 1'b0);

    // Start reasserted mid-stream with different data is ignored.
    ready_mode = 1;
    issue(3'd3, 3'd3, 1'b0, 1'b1, 1'b1);

    // Randomised captures.
    for (int t = 0; t < 24; t++) begin
      logic [2:0] m;
      logic [2:0] n;
      logic       de;
      m  = 3'($urandom_range(0, 6));
      n  = 3'($urandom_range(0, 6));
      de = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 25; i++) vals[i] = 16'($urandom);
      ready_mode = int'($urandom_range(0, 2));
      issue(m, n, de, 1'b1, ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
